// File: rtl/sequential_alu.sv
// sequential_alu: FSM-sequenced ALU; single-cycle ops plus optional shift-add multiplier (enabled by ALU_MUL_EN)
module sequential_alu #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] alu_out,
  output logic         cout,
  output logic         z_flag,
  output logic         n_flag,
  output logic         v_flag
);
  localparam int L = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_MUL_EN
  localparam logic [1:0] EXEC = 2'd1;
`endif
  logic [1:0]   state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic         cout_q, cout_d, z_q, z_d, v_q, v_d, err_q, err_d;
  logic [N:0]   add_w, sub_w, shl_w;
  logic [N-1:0] r;
  logic         c, v, rsv;
`ifdef ALU_MUL_EN
  logic [2*N-1:0] mc_q, mc_d, acc_q, acc_d, prod;
  logic [N-1:0]   mb_q, mb_d;
  logic [L-1:0]   cnt_q, cnt_d;
  assign prod = acc_q + (mb_q[0] ? mc_q : '0);
  assign busy = state_q == EXEC;
`else
  assign busy = 1'b0;
`endif
  assign done    = state_q == DONE;
  assign err     = err_q;
  assign alu_out = out_q;
  assign cout    = cout_q;
  assign z_flag  = z_q;
  assign n_flag  = out_q[N-1];
  assign v_flag  = v_q;
  assign add_w = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  assign sub_w = {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
  assign shl_w = {1'b0, x} << y[L-1:0];
  // single-cycle datapath: result and flags from the live operands on the accepting edge
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    rsv = 1'b0;
    case (op)
      3'b000: begin
        r = add_w[N-1:0];
        c = add_w[N];
        v = (x[N-1] == y[N-1]) && (add_w[N-1] != x[N-1]);
      end
      3'b001: begin
        r = sub_w[N-1:0];
        c = sub_w[N];
        v = (x[N-1] != y[N-1]) && (sub_w[N-1] != x[N-1]);
      end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: begin
        r = shl_w[N-1:0];
        c = (y[L-1:0] != '0) && shl_w[N];
      end
      default: rsv = 1'b1;
    endcase
  end
  // FSM next state; outputs change only on the edge that enters DONE
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    cout_d = cout_q;
    z_d = z_q;
    v_d = v_q;
    err_d = 1'b0;
`ifdef ALU_MUL_EN
    mc_d = mc_q;
    mb_d = mb_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (start) begin
`ifdef ALU_MUL_EN
        if (op == 3'b110) begin
          state_d = EXEC;
          mc_d = {{N{1'b0}}, x};
          mb_d = y;
          acc_d = '0;
          cnt_d = '0;
        end else
`endif
        begin
          state_d = DONE;
          out_d = r;
          cout_d = c;
          z_d = r == '0;
          v_d = v;
          err_d = rsv;
        end
      end
`ifdef ALU_MUL_EN
      EXEC: begin
        acc_d = prod;
        mc_d = mc_q << 1;
        mb_d = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == L'(N-1)) begin
          state_d = DONE;
          out_d = prod[N-1:0];
          cout_d = |prod[2*N-1:N];
          z_d = prod[N-1:0] == '0;
          v_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      out_q <= '0;
      cout_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
      err_q <= 1'b0;
`ifdef ALU_MUL_EN
      mc_q <= '0;
      mb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      cout_q <= cout_d;
      z_q <= z_d;
      v_q <= v_d;
      err_q <= err_d;
`ifdef ALU_MUL_EN
      mc_q <= mc_d;
      mb_q <= mb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_sequential_alu.sv
// tb_sequential_alu: directed vectors for sequential_alu (N=16); expectations follow ALU_MUL_EN
module tb_sequential_alu;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, cin = 1'b0;
  logic [2:0] op = 3'b000;
  logic [15:0] x = '0, y = '0;
  logic busy, done, err, cout, z_flag, n_flag, v_flag;
  logic [15:0] alu_out;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sequential_alu #(.N(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .x(x), .y(y), .cin(cin),
    .busy(busy), .done(done), .err(err), .alu_out(alu_out),
    .cout(cout), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic c, output int lat, output int nb);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b; cin = c;
    @(negedge clk);
    start = 1'b0; op = 3'b000; x = ~a; y = ~b; cin = ~c;
    lat = 1;
    nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      start = busy;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask
  task automatic vec(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic [15:0] eo, input logic ec, input logic ev,
                     input logic ee, input int elat, input int enb);
    int lat, nb;
    issue(o, a, b, c, lat, nb);
    check({tag, ".done"}, done, 1);
    check({tag, ".lat"}, lat, elat);
    check({tag, ".busy"}, nb, enb);
    check({tag, ".out"}, alu_out, eo);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".z"}, z_flag, eo == 16'h0);
    check({tag, ".n"}, n_flag, eo[15]);
    check({tag, ".v"}, v_flag, ev);
    check({tag, ".err"}, err, ee);
    @(negedge clk);
    check({tag, ".pulse"}, {done, err}, 2'b00);
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".out"}, alu_out, 16'h0);
    check({tag, ".flags"}, {cout, z_flag, n_flag, v_flag}, 4'b0000);
    check({tag, ".ctl"}, {busy, done, err}, 3'b000);
  endtask
  initial begin
    int dones;
    repeat (2) @(negedge clk);
    check_reset("rst");
    resetn = 1'b1;
    vec("add_wrap", 3'b000, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
    vec("sub_ovf",  3'b001, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1, 0);
    vec("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1, 0);
    vec("sub_brw",  3'b001, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1, 0);
    vec("sub_eq",   3'b001, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
    vec("and",      3'b010, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 1, 0);
    vec("or",       3'b011, 16'hF0F0, 16'h3C3C, 1'b0, 16'hFCFC, 1'b0, 1'b0, 1'b0, 1, 0);
    vec("xor",      3'b100, 16'hF0F0, 16'h3C3C, 1'b0, 16'hCCCC, 1'b0, 1'b0, 1'b0, 1, 0);
    vec("shl1",     3'b101, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1, 0);
    vec("shl0",     3'b101, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1, 0);
    vec("shl4",     3'b101, 16'h1234, 16'h0014, 1'b0, 16'h2340, 1'b1, 1'b0, 1'b0, 1, 0);
    vec("rsv7",     3'b111, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0);
`ifdef ALU_MUL_EN
    vec("mul",      3'b110, 16'h0100, 16'h0101, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0, 17, 16);
    vec("mul_sm",   3'b110, 16'h0007, 16'h0009, 1'b0, 16'h003F, 1'b0, 1'b0, 1'b0, 17, 16);
`else
    vec("rsv6",     3'b110, 16'h0100, 16'h0101, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0);
`endif
    @(negedge clk);
    start = 1'b1; op = 3'b000; x = 16'h0001; y = 16'h0001; cin = 1'b0;
    @(negedge clk);
    x = 16'h0002; y = 16'h0002;
    check("dstart.done", done, 1);
    @(negedge clk);
    start = 1'b0;
    check("dstart.idle", done, 0);
    check("dstart.out", alu_out, 16'h0002);
    @(negedge clk);
    check("dstart.nodone", done, 0);
    @(negedge clk);
    start = 1'b1; op = 3'b110; x = 16'h0100; y = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0; start = 1'b1; op = 3'b000; x = 16'h0003; y = 16'h0004;
    @(negedge clk);
    check_reset("midrst");
    resetn = 1'b1; start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst.nodone", dones, 0);
    vec("add34", 3'b000, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
